// File: rtl/usb_rx_fifo.sv
// usb_rx_fifo: full-speed USB receive front end. Synchronises D+/D-, recovers
// bit timing from D+ edges, NRZI-decodes, removes stuffed bits, frames
// SYNC/PID/payload/EOP and queues payload bytes in a small FIFO with a
// valid/ready output handshake.
// Optional build macro: USB_RX_CRC16_CHECK_EN adds a CRC16 residual check on
// DATA0/DATA1 packets; without it DATA packets close with rx_done on a good EOP.
//
// state   | meaning
// S_IDLE  | line idle, waiting for the first K of SYNC
// S_SYNC  | collecting the SYNC byte (must be 8'h80)
// S_PID   | collecting and checking the PID byte
// S_BYTES | collecting payload bytes into the FIFO
// S_EOP   | SE0 seen on a byte boundary, waiting for SE0 SE0 J
// S_ERR   | packet aborted, waiting for 8 idle J bit times
module usb_rx_fifo #(
  parameter int CLKS_PER_BIT = 10,
  parameter int FIFO_DEPTH   = 8,
  parameter int MAX_BYTES    = 66
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          d_plus,
  input  logic                          d_minus,
  output logic [2:0]                    rx_packet,
  output logic [7:0]                    rx_data,
  output logic                          rx_data_valid,
  input  logic                          rx_data_ready,
  output logic                          rx_done,
  output logic                          rx_error,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(MAX_BYTES + 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   DEPTH  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] MAXB   = BW'(MAX_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_BYTES, S_EOP, S_ERR} state_t;

  state_t state, state_next;

  logic dp_meta, dp_s, dp_d, dm_meta, dm_s;
  logic [TW-1:0] timer;
  logic dp_edge, strobe, se0, j_line, k_line;
  logic line_prev, nrzi_bit, stuff_slot, data_bit;
  logic [2:0] bit_cnt, ones_cnt, idle_cnt;
  logic [1:0] se0_cnt;
  logic [6:0] byte_sr;
  logic [7:0] byte_val;
  logic [BW-1:0] byte_cnt;
  logic pid_ok;
  logic [2:0] pid_class;
  logic err_now, done_now, push_req, pid_take, crc_bad;

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, head_next;
  logic [AW:0] count;
  logic fifo_full, pop;

  // Two-flop synchronisers plus a delayed D+ copy for edge detection; idle is J
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_meta <= 1'b1;
      dp_s    <= 1'b1;
      dp_d    <= 1'b1;
      dm_meta <= 1'b0;
      dm_s    <= 1'b0;
    end else begin
      dp_meta <= d_plus;
      dp_s    <= dp_meta;
      dp_d    <= dp_s;
      dm_meta <= d_minus;
      dm_s    <= dm_meta;
    end
  end

  assign dp_edge = dp_s ^ dp_d;
  assign strobe  = (timer == '0) && !dp_edge;
  assign se0     = !dp_s && !dm_s;
  assign j_line  = dp_s && !dm_s;
  assign k_line  = !dp_s && dm_s;

  // Bit timer: half a bit after each D+ edge, then one full bit per sample
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)             timer <= T_FULL;
    else if (dp_edge)       timer <= T_HALF;
    else if (timer == '0)   timer <= T_FULL;
    else                    timer <= timer - 1'b1;
  end

  assign nrzi_bit   = (dp_s == line_prev);
  assign stuff_slot = (ones_cnt == 3'd6);
  assign data_bit   = strobe && !se0 && !stuff_slot;
  assign byte_val   = {nrzi_bit, byte_sr};
  assign pid_ok     = (byte_val[3:0] == ~byte_val[7:4]);

  // PID class from the PID nibble
  always_comb begin
    pid_class = 3'd7;
    case (byte_val[3:0])
      4'h9: pid_class = 3'd1;
      4'h1: pid_class = 3'd2;
      4'h3: pid_class = 3'd3;
      4'hB: pid_class = 3'd4;
      4'h2: pid_class = 3'd5;
      4'hA: pid_class = 3'd6;
      default: pid_class = 3'd7;
    endcase
  end

  assign fifo_full = (count == DEPTH);
  assign pop       = rx_data_valid && rx_data_ready;

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_next;
  end

  // FSM next state and per-sample actions
  always_comb begin
    state_next = state;
    err_now    = 1'b0;
    done_now   = 1'b0;
    push_req   = 1'b0;
    pid_take   = 1'b0;
    if (strobe) begin
      case (state)
        S_IDLE: if (k_line) state_next = S_SYNC;
        S_SYNC, S_PID, S_BYTES: begin
          if (se0) begin
            if (state == S_BYTES && bit_cnt == 3'd0) begin
              state_next = S_EOP;
            end else begin
              err_now    = 1'b1;
              state_next = S_ERR;
            end
          end else if (stuff_slot) begin
            if (nrzi_bit) begin
              err_now    = 1'b1;
              state_next = S_ERR;
            end
          end else if (bit_cnt == 3'd7) begin
            case (state)
              S_SYNC: begin
                if (byte_val == 8'h80) begin
                  state_next = S_PID;
                end else begin
                  err_now    = 1'b1;
                  state_next = S_ERR;
                end
              end
              S_PID: begin
                pid_take = 1'b1;
                if (pid_ok) begin
                  state_next = S_BYTES;
                end else begin
                  err_now    = 1'b1;
                  state_next = S_ERR;
                end
              end
              default: begin
                // over-long packet or no room: drop the byte, keep FIFO contents
                if (byte_cnt == MAXB || (fifo_full && !pop)) begin
                  err_now    = 1'b1;
                  state_next = S_ERR;
                end else begin
                  push_req = 1'b1;
                end
              end
            endcase
          end
        end
        S_EOP: begin
          if (j_line) begin
            if (se0_cnt == 2'd2) begin
              if (crc_bad) err_now  = 1'b1;
              else         done_now = 1'b1;
              state_next = S_IDLE;
            end else begin
              err_now    = 1'b1;
              state_next = S_ERR;
            end
          end else if (!se0) begin
            err_now    = 1'b1;
            state_next = S_ERR;
          end
        end
        S_ERR: if (j_line && idle_cnt == 3'd7) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Bit assembly, unstuffing, and per-packet counters
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      line_prev <= 1'b1;
      bit_cnt   <= 3'd0;
      ones_cnt  <= 3'd0;
      byte_sr   <= 7'd0;
      byte_cnt  <= '0;
      se0_cnt   <= 2'd0;
      idle_cnt  <= 3'd0;
    end else begin
      if (strobe && !se0) line_prev <= dp_s;
      if (state == S_IDLE) begin
        ones_cnt <= 3'd0;
        byte_cnt <= '0;
        bit_cnt  <= 3'd0;
        if (strobe && k_line) begin
          byte_sr <= {nrzi_bit, byte_sr[6:1]};
          bit_cnt <= 3'd1;
        end
      end else if ((state == S_SYNC || state == S_PID || state == S_BYTES) && strobe && !se0) begin
        if (stuff_slot) begin
          ones_cnt <= 3'd0;
        end else begin
          ones_cnt <= nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
          byte_sr  <= {nrzi_bit, byte_sr[6:1]};
          bit_cnt  <= bit_cnt + 3'd1;
        end
      end
      if (push_req) byte_cnt <= byte_cnt + 1'b1;
      if (state == S_BYTES && state_next == S_EOP)
        se0_cnt <= 2'd1;
      else if (state == S_EOP && strobe && se0 && se0_cnt != 2'd2)
        se0_cnt <= se0_cnt + 2'd1;
      if (state != S_ERR)   idle_cnt <= 3'd0;
      else if (strobe)      idle_cnt <= j_line ? idle_cnt + 3'd1 : 3'd0;
    end
  end

  // Packet class and status pulses
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_packet <= 3'd0;
      rx_done   <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      if (pid_take) rx_packet <= pid_ok ? pid_class : 3'd7;
      rx_done  <= done_now;
      rx_error <= err_now;
    end
  end

`ifdef USB_RX_CRC16_CHECK_EN
  logic [15:0] crc;
  logic        is_data;

  // CRC16 over payload bits of DATA packets, in received (LSB-first) order
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc     <= 16'hFFFF;
      is_data <= 1'b0;
    end else begin
      if (pid_take) is_data <= pid_ok && (pid_class == 3'd3 || pid_class == 3'd4);
      if (state == S_IDLE)
        crc <= 16'hFFFF;
      else if (state == S_BYTES && data_bit)
        crc <= {crc[14:0], 1'b0} ^ ((nrzi_bit ^ crc[15]) ? 16'h8005 : 16'h0000);
    end
  end

  assign crc_bad = is_data && (crc != 16'h800D);
`else
  assign crc_bad = 1'b0;
`endif

  // FIFO storage; contents need no reset since occupancy is cleared
  always_ff @(posedge clk) begin
    if (push_req) mem[wr_ptr] <= byte_val;
  end

  assign head_next     = pop ? rd_ptr + 1'b1 : rd_ptr;
  assign rx_data_valid = (count != '0);
  assign fifo_count    = count;

  // FIFO pointers, occupancy and registered head byte
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rx_data <= 8'd0;
    end else begin
      if (push_req) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      case ({push_req, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // a byte written into the slot that becomes the head bypasses the array
      rx_data <= (push_req && wr_ptr == head_next) ? byte_val : mem[head_next];
    end
  end

endmodule

// File: tb/tb_usb_rx_fifo.sv
// tb_usb_rx_fifo: drives NRZI/bit-stuffed USB packets onto D+/D- and checks
// payload bytes and done/error pulses through decoupled scoreboard monitors.
module tb_usb_rx_fifo;
  localparam int CPB   = 10;
  localparam int DEPTH = 8;
  localparam int MAXB  = 66;

  logic clk = 1'b0;
  logic n_rst, d_plus, d_minus, rx_data_ready;
  logic [2:0] rx_packet;
  logic [7:0] rx_data;
  logic rx_data_valid, rx_done, rx_error;
  logic [$clog2(DEPTH):0] fifo_count;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  int evt_q[$];
  logic [7:0] payload[$];
  int rdy_mode = 0;
  int last_pkt = 0;
  bit cur_j;
  int ones;
  logic [7:0] good_pids [7] = '{8'h69, 8'hE1, 8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h2D};

  usb_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .n_rst(n_rst), .d_plus(d_plus), .d_minus(d_minus),
    .rx_packet(rx_packet), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready), .rx_done(rx_done), .rx_error(rx_error),
    .fifo_count(fifo_count));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // USB PID table; anything failing the complement check is class 7
  function automatic int exp_packet(input logic [7:0] pid);
    if (pid[3:0] != ~pid[7:4]) return 7;
    case (pid)
      8'h69: return 1;
      8'hE1: return 2;
      8'hC3: return 3;
      8'h4B: return 4;
      8'hD2: return 5;
      8'h5A: return 6;
      default: return 7;
    endcase
  endfunction

  // consumer ready: 0 never, 1 always, 2 random
  initial begin
    rx_data_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 2)      rx_data_ready = 1'($urandom_range(0, 1));
      else if (rdy_mode == 1) rx_data_ready = 1'b1;
      else                    rx_data_ready = 1'b0;
    end
  end

  // byte monitor: every accepted byte is checked against the scoreboard
  initial forever begin
    @(negedge clk);
    if (n_rst === 1'b1 && rx_data_valid && rx_data_ready) begin
      if (exp_q.size() == 0) chk("byte_unexpected_qsize", exp_q.size(), 1);
      else                   chk("rx_data", int'(rx_data), int'(exp_q.pop_front()));
    end
  end

  // event monitor: 1 = done, 2 = error, 3 = both at once
  initial forever begin
    @(negedge clk);
    if (n_rst === 1'b1 && (rx_done || rx_error)) begin
      int code;
      code = (rx_done ? 1 : 0) + (rx_error ? 2 : 0);
      if (evt_q.size() == 0) chk("event_unexpected", code, 0);
      else                   chk("event", code, evt_q.pop_front());
    end
  end

  task automatic hold_line(input bit p, input bit m, input int bits);
    d_plus = p;
    d_minus = m;
    repeat (bits * CPB) @(negedge clk);
  endtask

  task automatic raw_bit(input bit b);
    if (!b) cur_j = !cur_j;
    hold_line(cur_j, !cur_j, 1);
  endtask

  task automatic send_bit(input bit b);
    raw_bit(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      raw_bit(1'b0);
      ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic start_pkt(input logic [7:0] sync);
    cur_j = 1'b1;
    ones = 0;
    send_byte(sync);
  endtask

  task automatic end_pkt();
    hold_line(1'b0, 1'b0, 2);
    cur_j = 1'b1;
    hold_line(1'b1, 1'b0, 12);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  // reference: the FIFO absorbs at most 'room' bytes, packets cap at MAXB
  task automatic run_packet(input logic [7:0] pid, input int room);
    bit bad;
    int keep;
    bad  = (pid[3:0] != ~pid[7:4]);
    keep = payload.size();
    if (keep > MAXB) keep = MAXB;
    if (keep > room) keep = room;
    if (!bad) for (int i = 0; i < keep; i++) exp_q.push_back(payload[i]);
    evt_q.push_back((bad || payload.size() > keep) ? 2 : 1);
    last_pkt = exp_packet(pid);
    start_pkt(8'h80);
    send_byte(pid);
    foreach (payload[i]) send_byte(payload[i]);
    end_pkt();
    chk("events_seen", evt_q.size(), 0);
    chk("rx_packet", int'(rx_packet), last_pkt);
  endtask

  task automatic do_reset();
    #3 n_rst = 1'b0;
    exp_q.delete();
    evt_q.delete();
    repeat (3) @(negedge clk);
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("rst_valid", int'(rx_data_valid), 0);
    chk("rst_rx_packet", int'(rx_packet), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_done_err", int'({rx_done, rx_error}), 0);
    last_pkt = 0;
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    n_rst = 1'b1;
    d_plus = 1'b1;
    d_minus = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // IN token carrying 01 10, consumer always ready
    rdy_mode = 1;
    payload = '{8'h01, 8'h10};
    run_packet(8'h69, 1000);
    drain("in_drain");

    // DATA0 FF FF exercises stuffed-bit removal
    payload = '{8'hFF, 8'hFF};
    run_packet(8'hC3, 1000);
    drain("stuff_drain");

    // seven unstuffed ones after a valid PID
    evt_q.push_back(2);
    last_pkt = 3;
    start_pkt(8'h80);
    send_byte(8'hC3);
    for (int i = 0; i < 7; i++) raw_bit(1'b1);
    cur_j = 1'b1;
    hold_line(1'b1, 1'b0, 12);
    chk("stuff_err_seen", evt_q.size(), 0);
    chk("stuff_err_pkt", int'(rx_packet), last_pkt);

    // SE0 three bits into a byte
    evt_q.push_back(2);
    last_pkt = 2;
    start_pkt(8'h80);
    send_byte(8'hE1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    end_pkt();
    chk("midbyte_se0_seen", evt_q.size(), 0);
    chk("midbyte_se0_pkt", int'(rx_packet), last_pkt);

    // corrupted SYNC: rx_packet must hold its previous value
    evt_q.push_back(2);
    start_pkt(8'h40);
    send_byte(8'h69);
    send_byte(8'h55);
    end_pkt();
    chk("bad_sync_seen", evt_q.size(), 0);
    chk("bad_sync_pkt", int'(rx_packet), last_pkt);

    // randomized packets with a random-ready consumer
    rdy_mode = 2;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] pid;
      if (n % 6 == 5) begin
        do pid = 8'($urandom); while (pid[3:0] == ~pid[7:4]);
      end else begin
        pid = good_pids[$urandom_range(0, 6)];
      end
      payload.delete();
      repeat ($urandom_range(0, 8)) payload.push_back(8'($urandom));
      run_packet(pid, 1000);
      drain("rand_drain");
    end

    // one byte beyond the packet limit
    payload.delete();
    repeat (MAXB + 1) payload.push_back(8'($urandom));
    run_packet(8'h4B, 1000);
    drain("maxb_drain");

    // overflow with a stalled consumer, then drain
    rdy_mode = 0;
    payload.delete();
    for (int i = 0; i < 10; i++) payload.push_back(8'(8'hA0 + i));
    run_packet(8'h4B, DEPTH);
    chk("ovf_fifo_count", int'(fifo_count), DEPTH);
    chk("ovf_valid", int'(rx_data_valid), 1);
    rdy_mode = 1;
    drain("ovf_drain");
    repeat (3) @(negedge clk);
    chk("ovf_empty", int'(fifo_count), 0);

    // overflow again, then reset with the FIFO full
    rdy_mode = 0;
    run_packet(8'h4B, DEPTH);
    chk("ovf2_fifo_count", int'(fifo_count), DEPTH);
    do_reset();

    // normal traffic after reset
    rdy_mode = 2;
    payload = '{8'h5C, 8'h3E, 8'h7F};
    run_packet(8'hE1, 1000);
    drain("post_rst_drain");

    chk("final_exp_q", exp_q.size(), 0);
    chk("final_evt_q", evt_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
